note_recorder: RTL

- Sits between the matrix keyboard scanner and the beeper driver in the electric piano.
- Takes the debounced, active-high 16-key level vector and normally passes it straight through to the beeper.
- On request, it records the melody as (note, duration) entries in an internal RAM.
- On a later request, it replays those entries to the beeper as one-hot key vectors with the recorded timing.

---
 rtl/note_recorder.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/note_recorder.sv
// Piano note recorder: passes key levels to the beeper, records (note, duration)
// entries into a small RAM on request, and replays them with the recorded timing.
module note_recorder #(
    parameter int unsigned CLK_FREQ = 12_000_000,
    parameter int unsigned TICK_MS  = 10,
    parameter int unsigned DEPTH    = 64,
    parameter int unsigned AW       = 6,
    parameter int unsigned DUR_W    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [15:0]   key_in,
    input  logic          rec_req,
    input  logic          play_req,
    input  logic          stop_req,
    output logic [15:0]   note_out,
    output logic [1:0]    state,
    output logic [AW:0]   rec_len,
    output logic          full
);

    localparam int unsigned TICK_CYC = CLK_FREQ / 1000 * TICK_MS;
    localparam int unsigned TW       = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam int unsigned EW       = 5 + DUR_W;
    localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_CYC - 1);
    localparam logic [DUR_W-1:0] DMAX      = '1;
    localparam logic [AW:0]      DEPTH_L   = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REC       = 2'd1,
        PLAY_LOAD = 2'd2,
        PLAY_HOLD = 2'd3
    } state_t;

    state_t            cur_state, nxt_state;
    logic [TW-1:0]     tick_cnt;
    logic              tick;
    logic [AW:0]       wr_ptr, rd_ptr, wr_cnt_nxt;
    logic [AW:0]       rec_len_q;
    logic              full_q;
    logic [4:0]        cur_note, new_note, hold_note;
    logic [DUR_W-1:0]  dur, hold_dur, hold_cnt;
    logic              load_ph;
    logic              extend;
    logic              wr_en;
    logic [EW-1:0]     wr_data, rd_data;
    logic [EW-1:0]     mem [DEPTH];

    function automatic logic [4:0] encode(input logic [15:0] k);
        logic [4:0] n;
        n = 5'd16;
        for (int unsigned i = 16; i > 0; i--) begin
            if (k[i-1]) n = 5'(i - 1);
        end
        return n;
    endfunction

    function automatic logic [15:0] decode(input logic [4:0] n);
        logic [15:0] v;
        v = '0;
        if (!n[4]) v[n[3:0]] = 1'b1;
        return v;
    endfunction

    assign state   = cur_state;
    assign rec_len = rec_len_q;
    assign full    = full_q;

    assign new_note   = encode(key_in);
    assign extend     = (new_note == cur_note) && (dur != DMAX);
    assign tick       = ((cur_state == REC) || (cur_state == PLAY_HOLD)) && (tick_cnt == TICK_LAST);
    assign wr_data    = {cur_note, dur};
    assign wr_cnt_nxt = wr_ptr + {{AW{1'b0}}, wr_en};

    always_comb begin
        nxt_state = cur_state;
        wr_en     = 1'b0;
        case (cur_state)
            IDLE: begin
                if (stop_req)
                    nxt_state = IDLE;
                else if (rec_req)
                    nxt_state = REC;
                else if (play_req && (rec_len_q != '0))
                    nxt_state = PLAY_LOAD;
            end
            REC: begin
                if (stop_req) begin
                    wr_en     = (dur != '0);
                    nxt_state = IDLE;
                end else if (tick && !extend && (dur != '0)) begin
                    wr_en = 1'b1;
                    if (wr_ptr + 1'b1 == DEPTH_L) nxt_state = IDLE;
                end
            end
            PLAY_LOAD: begin
                if (stop_req)
                    nxt_state = IDLE;
                else if (load_ph)
                    nxt_state = PLAY_HOLD;
            end
            PLAY_HOLD: begin
                if (stop_req)
                    nxt_state = IDLE;
                else if (tick && (hold_cnt + 1'b1 == hold_dur))
                    nxt_state = (rd_ptr + 1'b1 < rec_len_q) ? PLAY_LOAD : IDLE;
            end
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cur_state <= IDLE;
        else
            cur_state <= nxt_state;
    end

    // Counter restarts on every state change so each state sees a full first tick period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tick_cnt <= '0;
        else if ((nxt_state != cur_state) || !((cur_state == REC) || (cur_state == PLAY_HOLD)) || tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
        rd_data <= mem[rd_ptr[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            note_out  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rec_len_q <= '0;
            full_q    <= 1'b0;
            cur_note  <= '0;
            dur       <= '0;
            hold_note <= '0;
            hold_dur  <= '0;
            hold_cnt  <= '0;
            load_ph   <= 1'b0;
        end else begin
            case (cur_state)
                IDLE: begin
                    note_out <= key_in;
                    if (nxt_state == REC) begin
                        wr_ptr    <= '0;
                        cur_note  <= new_note;
                        dur       <= '0;
                        full_q    <= 1'b0;
                        rec_len_q <= '0;
                    end else if (nxt_state == PLAY_LOAD) begin
                        rd_ptr  <= '0;
                        load_ph <= 1'b0;
                    end
                end
                REC: begin
                    note_out <= key_in;
                    wr_ptr   <= wr_cnt_nxt;
                    if (stop_req) begin
                        rec_len_q <= wr_cnt_nxt;
                        full_q    <= (wr_cnt_nxt == DEPTH_L);
                    end else if (tick) begin
                        if (extend) begin
                            dur <= dur + 1'b1;
                        end else begin
                            cur_note <= new_note;
                            dur      <= DUR_W'(1);
                        end
                        if (nxt_state == IDLE) begin
                            rec_len_q <= DEPTH_L;
                            full_q    <= 1'b1;
                        end
                    end
                end
                PLAY_LOAD: begin
                    load_ph <= 1'b1;
                    // note_out only switches once the new entry is captured, so it never blanks between notes.
                    if (nxt_state == PLAY_HOLD) begin
                        hold_note <= rd_data[EW-1:DUR_W];
                        hold_dur  <= rd_data[DUR_W-1:0];
                        hold_cnt  <= '0;
                        note_out  <= decode(rd_data[EW-1:DUR_W]);
                    end
                end
                PLAY_HOLD: begin
                    note_out <= decode(hold_note);
                    if (tick) hold_cnt <= hold_cnt + 1'b1;
                    if (nxt_state == PLAY_LOAD) begin
                        rd_ptr  <= rd_ptr + 1'b1;
                        load_ph <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
